pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: REG_W, 4, register-index width of every source/destination field.
REQ-002 Parameter: LOAD_STALL_CYCLES, 1, total stall cycles per load-use hazard (legal range 1..8).
REQ-003 Parameter: FETCH_LAT, 1, extra flush cycles after a taken branch (legal range 0..4).
REQ-004 Parameter: MEM_TIMEOUT, 64, MEM_WAIT cycles before timeout flag sets.
REQ-005 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-006 Port: rst  in  1  asynchronous, active-high reset.
REQ-007 Port: id_src1, id_src2, id_src3  in  REG_W each  register indices read by the instruction in ID.
REQ-008 Port: id_uses_src  in  3  per-source valid; bit0=src1, bit1=src2, bit2=src3.
REQ-009 Port: exe_dest  in  REG_W  destination index of the instruction in EXE.
REQ-010 Port: exe_wb_en, exe_rd_mem_en  in  1 each  EXE instruction writes back / is a load.
REQ-011 Port: branch_taken  in  1  EXE resolved a taken jump this cycle.
REQ-012 Port: mem_req, mem_ready  in  1 each  MEM-stage data access request / data memory completion.
REQ-013 Port: perf_clr  in  1  synchronous clear of both performance counters.
REQ-014 Port: pc_en  out  1  PC update enable (1 = advance/redirect).
REQ-015 Port: ifid_stall, ifid_flush  out  1 each  hold / clear-to-NOP the IF/ID register.
REQ-016 Port: idexe_bubble, pipe_hold  out  1 each  load NOP into ID/EXE / freeze ID/EXE and later stages.
REQ-017 Port: state  out  2  current FSM state code.
REQ-018 Port: mem_timeout  out  1  sticky error flag.
REQ-019 Port: stall_cnt, flush_cnt  out  16 each  performance counters.

Function
REQ-020 hazard = exe_rd_mem_en & exe_wb_en & OR over i of (id_uses_src[i] & id_src_i == exe_dest).
REQ-021 memwait = mem_req & ~mem_ready; priority per cycle: memwait > branch_taken > hazard.
REQ-022 FSM states: RUN=0, LOAD_STALL=1, FLUSH=2, MEM_WAIT=3.
REQ-023 RUN, no event: pc_en=1, all other control outputs 0; stay RUN.
REQ-024 Any state except MEM_WAIT, memwait: pc_en=0, ifid_stall=1, pipe_hold=1, idexe_bubble=0, same cycle; next MEM_WAIT.
REQ-025 MEM_WAIT, mem_ready=0: outputs as REQ-024, wait counter increments; mem_ready=1: RUN outputs same cycle, next RUN, counter cleared.
REQ-026 Wait counter reaching MEM_TIMEOUT sets mem_timeout; it stays set until rst; FSM keeps waiting.
REQ-027 RUN or LOAD_STALL, branch_taken (no memwait): pc_en=1, ifid_flush=1, idexe_bubble=1 same cycle; next FLUSH if FETCH_LAT>0 else RUN; pending load stall abandoned.
REQ-028 FLUSH: pc_en=1, ifid_flush=1, idexe_bubble=0 for exactly FETCH_LAT cycles, then RUN; branch_taken during FLUSH ignored.
REQ-029 RUN, hazard (no memwait, no branch): pc_en=0, ifid_stall=1, idexe_bubble=1 same cycle; next LOAD_STALL if LOAD_STALL_CYCLES>1 else RUN.
REQ-030 LOAD_STALL: outputs as REQ-029 for LOAD_STALL_CYCLES-1 cycles, then RUN.
REQ-031 ifid_stall and ifid_flush never both 1; idexe_bubble and pipe_hold never both 1.
REQ-032 stall_cnt += 1 each cycle pc_en=0; flush_cnt += 1 on each REQ-027 event; both saturate at 0xFFFF.
REQ-033 perf_clr=1 zeroes both counters next edge, overriding that cycle's increment.
REQ-034 state output equals FSM register; outputs REQ-023..030 are combinational from state, counters and inputs.

Reset
REQ-035 rst=1 asynchronously forces: state=RUN, all internal counters 0, stall_cnt=0, flush_cnt=0, mem_timeout=0.
REQ-036 While rst=1: pc_en=1, ifid_stall=ifid_flush=idexe_bubble=pipe_hold=0 regardless of inputs.
REQ-037 rst asserted mid-MEM_WAIT, LOAD_STALL or FLUSH abandons it; first cycle after release behaves as RUN.

Verification
REQ-038 Load-use: exe_rd_mem_en=1, exe_wb_en=1, exe_dest=3, id_src2=3, id_uses_src=010, LOAD_STALL_CYCLES=2 -> 2 cycles pc_en=0, idexe_bubble=1; stall_cnt=2.
REQ-039 Branch: branch_taken=1 one cycle, FETCH_LAT=1 -> ifid_flush=1 for 2 cycles, idexe_bubble=1 first cycle only, flush_cnt=1, state 0->2->0.
REQ-040 Mem wait: mem_req=1, mem_ready=0 for 5 cycles then 1 -> pipe_hold=1 exactly 5 cycles, state=3 during, stall_cnt=5.
REQ-041 Simultaneous: memwait, branch_taken and hazard all 1 -> MEM_WAIT outputs only; on mem_ready with branch_taken=1 -> flush next cycle.
REQ-042 Timeout/saturation: mem_ready held 0 for 64 cycles -> mem_timeout=1 at cycle 64 and persists; stall_cnt preloaded near 0xFFFF saturates at 0xFFFF.
REQ-043 Reset: rst pulsed during MEM_WAIT -> state=0, counters 0, mem_timeout=0 immediately, pc_en=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of hazard-controller signals between the pipeline datapath (master)
// and the hazard controller (slave).
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = 4
);
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic [REG_W-1:0] id_src3;
    logic [2:0]       id_uses_src;
    logic [REG_W-1:0] exe_dest;
    logic             exe_wb_en;
    logic             exe_rd_mem_en;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             perf_clr;
    logic             pc_en;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             idexe_bubble;
    logic             pipe_hold;
    logic [1:0]       state;
    logic             mem_timeout;
    logic [15:0]      stall_cnt;
    logic [15:0]      flush_cnt;

    modport master (
        output id_src1, id_src2, id_src3, id_uses_src, exe_dest, exe_wb_en,
               exe_rd_mem_en, branch_taken, mem_req, mem_ready, perf_clr,
        input  pc_en, ifid_stall, ifid_flush, idexe_bubble, pipe_hold, state,
               mem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_src1, id_src2, id_src3, id_uses_src, exe_dest, exe_wb_en,
               exe_rd_mem_en, branch_taken, mem_req, mem_ready, perf_clr,
        output pc_en, ifid_stall, ifid_flush, idexe_bubble, pipe_hold, state,
               mem_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and data
// memory wait holds, with a sticky memory timeout flag and perf counters.
module pipe_hazard_ctrl #(
    parameter int REG_W             = 4,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FETCH_LAT         = 1,
    parameter int MEM_TIMEOUT       = 64
) (
    input logic            clk,
    input logic            rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int LS_W   = (LOAD_STALL_CYCLES > 2) ? $clog2(LOAD_STALL_CYCLES) : 1;
    localparam int FL_W   = (FETCH_LAT > 2) ? $clog2(FETCH_LAT) : 1;
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [LS_W-1:0]   ls_cnt_r;
    logic [LS_W-1:0]   ls_cnt_nxt_s;
    logic [FL_W-1:0]   fl_cnt_r;
    logic [FL_W-1:0]   fl_cnt_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_nxt_s;
    logic [15:0]       stall_cnt_r;
    logic [15:0]       flush_cnt_r;
    logic              mem_timeout_r;
    logic [REG_W-1:0]  exe_dest_s;
    logic              hazard_s;
    logic              memwait_s;
    logic              flush_evt_s;
    logic              pc_en_s;
    logic              stall_s;
    logic              flush_s;
    logic              bubble_s;
    logic              hold_s;

    assign exe_dest_s = bus.exe_dest;
    assign memwait_s  = bus.mem_req & ~bus.mem_ready;
    assign hazard_s   = bus.exe_rd_mem_en & bus.exe_wb_en &
                        ((bus.id_uses_src[0] & (bus.id_src1 == exe_dest_s)) |
                         (bus.id_uses_src[1] & (bus.id_src2 == exe_dest_s)) |
                         (bus.id_uses_src[2] & (bus.id_src3 == exe_dest_s)));

    // Next-state and control outputs; memwait outranks branch, branch outranks hazard.
    always_comb begin
        next_state_s   = state_r;
        ls_cnt_nxt_s   = ls_cnt_r;
        fl_cnt_nxt_s   = fl_cnt_r;
        wait_cnt_nxt_s = wait_cnt_r;
        flush_evt_s    = 1'b0;
        pc_en_s        = 1'b1;
        stall_s        = 1'b0;
        flush_s        = 1'b0;
        bubble_s       = 1'b0;
        hold_s         = 1'b0;
        if (state_r == MEM_WAIT) begin
            if (memwait_s) begin
                pc_en_s = 1'b0;
                stall_s = 1'b0 | 1'b1;
                hold_s  = 1'b1;
                if (wait_cnt_r != WAIT_W'(MEM_TIMEOUT)) begin
                    wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r;
                end
            end else begin
                wait_cnt_nxt_s = '0;
                next_state_s   = RUN;
            end
        end else if (memwait_s) begin
            // The entry cycle is the first cycle of the wait.
            pc_en_s        = 1'b0;
            stall_s        = 1'b1;
            hold_s         = 1'b1;
            wait_cnt_nxt_s = WAIT_W'(1);
            next_state_s   = MEM_WAIT;
        end else begin
            case (state_r)
                FLUSH: begin
                    flush_s = 1'b1;
                    if (fl_cnt_r == '0) begin
                        next_state_s = RUN;
                    end else begin
                        fl_cnt_nxt_s = fl_cnt_r - FL_W'(1);
                    end
                end
                RUN, LOAD_STALL: begin
                    if (bus.branch_taken) begin
                        flush_s     = 1'b1;
                        bubble_s    = 1'b1;
                        flush_evt_s = 1'b1;
                        if (FETCH_LAT > 0) begin
                            next_state_s = FLUSH;
                            fl_cnt_nxt_s = FL_W'(FETCH_LAT - 1);
                        end else begin
                            next_state_s = RUN;
                        end
                    end else if (state_r == LOAD_STALL) begin
                        pc_en_s  = 1'b0;
                        stall_s  = 1'b1;
                        bubble_s = 1'b1;
                        if (ls_cnt_r == '0) begin
                            next_state_s = RUN;
                        end else begin
                            ls_cnt_nxt_s = ls_cnt_r - LS_W'(1);
                        end
                    end else if (hazard_s) begin
                        pc_en_s  = 1'b0;
                        stall_s  = 1'b1;
                        bubble_s = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            next_state_s = LOAD_STALL;
                            ls_cnt_nxt_s = LS_W'(LOAD_STALL_CYCLES - 2);
                        end else begin
                            next_state_s = RUN;
                        end
                    end else begin
                        next_state_s = RUN;
                    end
                end
                default: begin
                    next_state_s = RUN;
                end
            endcase
        end
    end

    // State, sequencing counters, sticky timeout and saturating perf counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= RUN;
            ls_cnt_r      <= '0;
            fl_cnt_r      <= '0;
            wait_cnt_r    <= '0;
            mem_timeout_r <= 1'b0;
            stall_cnt_r   <= 16'd0;
            flush_cnt_r   <= 16'd0;
        end else begin
            state_r    <= next_state_s;
            ls_cnt_r   <= ls_cnt_nxt_s;
            fl_cnt_r   <= fl_cnt_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            if (wait_cnt_nxt_s == WAIT_W'(MEM_TIMEOUT)) begin
                mem_timeout_r <= 1'b1;
            end else begin
                mem_timeout_r <= mem_timeout_r;
            end
            if (bus.perf_clr) begin
                stall_cnt_r <= 16'd0;
                flush_cnt_r <= 16'd0;
            end else begin
                if (!pc_en_s && (stall_cnt_r != 16'hFFFF)) begin
                    stall_cnt_r <= stall_cnt_r + 16'd1;
                end else begin
                    stall_cnt_r <= stall_cnt_r;
                end
                if (flush_evt_s && (flush_cnt_r != 16'hFFFF)) begin
                    flush_cnt_r <= flush_cnt_r + 16'd1;
                end else begin
                    flush_cnt_r <= flush_cnt_r;
                end
            end
        end
    end

    // Reset forces the free-running pipeline controls regardless of inputs.
    assign bus.pc_en        = rst | pc_en_s;
    assign bus.ifid_stall   = ~rst & stall_s;
    assign bus.ifid_flush   = ~rst & flush_s;
    assign bus.idexe_bubble = ~rst & bubble_s;
    assign bus.pipe_hold    = ~rst & hold_s;
    assign bus.state        = state_r;
    assign bus.mem_timeout  = mem_timeout_r;
    assign bus.stall_cnt    = stall_cnt_r;
    assign bus.flush_cnt    = flush_cnt_r;
endmodule
